apb_slave: RTL and testbench
============================

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_WIDTH, 16, data bus and register width.
- ADDR_WIDTH, 16, address bus width.
- NUM_REGS, 8, number of registers, word-indexed; valid range 3..256.
- ID_VALUE, 16'hA5B0, read-only value of register 0.

REQ-002 The block SHALL have the following ports:
- i_pclk  in  1  single clock.
- i_prst_n  in  1  asynchronous active-low reset.
- i_psel  in  1  APB select.
- i_pen  in  1  APB enable.
- i_pwrite  in  1  1=write, 0=read.
- i_paddr  in  ADDR_WIDTH  register index.
- i_pwdata  in  DATA_WIDTH  write data.
- o_pready  out  1  transfer complete.
- o_prdata  out  DATA_WIDTH  read data.
- o_pslverr  out  1  transfer error.
- i_wait_cfg  in  4  wait states to insert per transfer.
- i_status  in  DATA_WIDTH  live status, read-only register 1.
- o_ctrl  out  DATA_WIDTH  contents of register 2.
- o_wr_strobe  out  1  one-cycle pulse on a successful write.
- o_wr_idx  out  8  index of the register written, valid with o_wr_strobe.

Function
REQ-003 The block SHALL use a 3-state FSM: IDLE, WAIT, RESP.
- IDLE -> WAIT on a setup cycle (i_psel=1, i_pen=0).
- WAIT -> RESP when the wait counter is 0 and i_pen=1.
- RESP -> IDLE unconditionally.
REQ-004 On the setup-cycle edge the block SHALL load the wait counter from i_wait_cfg and latch i_paddr, i_pwrite and i_pwdata; i_wait_cfg changes mid-transfer SHALL have no effect.
REQ-005 In WAIT, the counter SHALL decrement by 1 on each cycle with i_psel=1 and i_pen=1 while the counter is nonzero.
REQ-006 o_pready SHALL be registered and SHALL be high only in RESP, so it is high in access cycle i_wait_cfg+1 (first access cycle when i_wait_cfg=0) for exactly one cycle.
REQ-007 An address SHALL be an error when i_paddr >= NUM_REGS, or when i_pwrite=1 and i_paddr is 0 or 1.
REQ-008 o_pslverr SHALL equal the error flag only while o_pready=1 and SHALL be 0 otherwise.
REQ-009 A read SHALL drive o_prdata in RESP as follows: register 0 -> ID_VALUE; register 1 -> i_status sampled on the WAIT->RESP edge; otherwise the register contents; an error read -> 0.
REQ-010 o_prdata SHALL be 0 whenever o_pready=0.
REQ-011 A non-error write SHALL update its register on the WAIT->RESP edge, so the new value is visible in RESP.
REQ-012 A non-error write SHALL pulse o_wr_strobe high for the RESP cycle with o_wr_idx = the register index.
REQ-013 An error write SHALL change no register and SHALL NOT pulse o_wr_strobe.
REQ-014 If i_psel falls while in WAIT (master abort), the block SHALL return to IDLE with no register update, no o_pready and no o_wr_strobe.
REQ-015 When i_psel=1 and i_pen=1 arrive while in IDLE (missing setup phase), the block SHALL ignore them.
REQ-016 A setup cycle presented during RESP SHALL be ignored; back-to-back transfers therefore need the standard IDLE or setup cycle after RESP.
REQ-017 o_ctrl SHALL continuously reflect register 2.
REQ-018 Address bits above bit 7 SHALL participate in the range check and SHALL NOT alias onto lower registers.

Reset
REQ-019 While i_prst_n=0 the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-020 While i_prst_n=0 the following outputs SHALL be 0: o_pready, o_prdata, o_pslverr, o_wr_strobe, o_wr_idx, o_ctrl.
REQ-021 While i_prst_n=0 all RW registers SHALL be 0.
REQ-022 Reset asserted mid-transfer SHALL abort that transfer with no register update.
REQ-023 The first setup cycle after reset release SHALL be accepted normally.

Structure
REQ-024 The package apb_pkg SHALL hold:
- the FSM state typedef (IDLE/WAIT/RESP);
- register index constants REG_ID=0, REG_STATUS=1, REG_CTRL=2.
REQ-025 The register array, write decode and read mux SHALL live in one sub-module, apb_slave_regfile; the FSM, wait counter and APB outputs SHALL stay in apb_slave.

Verification
REQ-026 Write 16'h1234 to index 2 with i_wait_cfg=0 -> o_pready high in the first access cycle; o_pslverr=0; o_wr_strobe with o_wr_idx=2; o_ctrl=16'h1234.
REQ-027 Read index 2 with i_wait_cfg=3 -> o_pready low for 3 access cycles, high in the 4th, with o_prdata=16'h1234.
REQ-028 Read index 0 -> o_prdata=16'hA5B0; then write index 0 -> o_pslverr=1, register 0 unchanged, no o_wr_strobe.
REQ-029 Read index NUM_REGS (8) -> o_pslverr=1, o_prdata=0; read 16'h0102 -> o_pslverr=1, no alias to index 2.
REQ-030 Drop i_psel after 1 wait cycle of a write of 16'hFFFF to index 3, then read index 3 -> 16'h0000.
REQ-031 Assert i_prst_n=0 during WAIT of a write to index 4 -> all outputs 0; a subsequent read of index 4 returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and register map for the APB register slave.
// Register indices and the transfer FSM state encoding.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam int REG_ID     = 0;
   localparam int REG_STATUS = 1;
   localparam int REG_CTRL   = 2;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register array, address/write decode and read mux of the APB slave.
// Registers 0 (ID) and 1 (status) are read-only views.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    NUM_REGS   = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hA5B0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic                  wr_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [DATA_WIDTH-1:0] status_i,
   output logic                  err_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [DATA_WIDTH-1:0] ctrl_o
);

   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] FIRST_RW = ADDR_WIDTH'(REG_CTRL);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [IW-1:0]         idx;
   logic                  in_range;

   // Full-width compare so upper address bits never alias
   assign in_range = addr_i < NREG;
   assign idx      = addr_i[IW-1:0];
   assign err_o    = !in_range || (wr_i && addr_i < FIRST_RW);
   assign ctrl_o   = regs_q[REG_CTRL];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[idx] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (!in_range) begin
         rdata_o = '0;
      end else if (idx == IW'(REG_ID)) begin
         rdata_o = ID_VALUE;
      end else if (idx == IW'(REG_STATUS)) begin
         rdata_o = status_i;
      end else begin
         rdata_o = regs_q[idx];
      end
   end

endmodule

// File: rtl/apb_slave.sv
// APB register slave: transfer FSM, wait-state counter, registered
// APB response outputs and write strobe around the register file.
module apb_slave
   import apb_pkg::*;
#(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    NUM_REGS   = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hA5B0
) (
   input  logic                  i_pclk,
   input  logic                  i_prst_n,
   input  logic                  i_psel,
   input  logic                  i_pen,
   input  logic                  i_pwrite,
   input  logic [ADDR_WIDTH-1:0] i_paddr,
   input  logic [DATA_WIDTH-1:0] i_pwdata,
   output logic                  o_pready,
   output logic [DATA_WIDTH-1:0] o_prdata,
   output logic                  o_pslverr,
   input  logic [3:0]            i_wait_cfg,
   input  logic [DATA_WIDTH-1:0] i_status,
   output logic [DATA_WIDTH-1:0] o_ctrl,
   output logic                  o_wr_strobe,
   output logic [7:0]            o_wr_idx
);

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  pready_q;
   logic                  pslverr_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  strobe_q;
   logic [7:0]            idx_q;

   logic                  fire;
   logic                  err;
   logic                  we;
   logic [DATA_WIDTH-1:0] rdata;

   assign fire = (state_q == WAIT) && i_psel && i_pen && (cnt_q == '0);
   assign we   = fire && write_q && !err;

   apb_slave_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ID_VALUE   (ID_VALUE)
   ) u_regfile (
      .clk_i    (i_pclk),
      .rst_ni   (i_prst_n),
      .we_i     (we),
      .wr_i     (write_q),
      .addr_i   (addr_q),
      .wdata_i  (wdata_q),
      .status_i (i_status),
      .err_o    (err),
      .rdata_o  (rdata),
      .ctrl_o   (o_ctrl)
   );

   always_ff @(posedge i_pclk or negedge i_prst_n) begin
      if (!i_prst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         strobe_q  <= 1'b0;
         idx_q     <= '0;
      end else begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         strobe_q  <= 1'b0;
         idx_q     <= '0;
         unique case (state_q)
            IDLE: begin
               if (i_psel && !i_pen) begin
                  state_q <= WAIT;
                  cnt_q   <= i_wait_cfg;
                  addr_q  <= i_paddr;
                  write_q <= i_pwrite;
                  wdata_q <= i_pwdata;
               end
            end
            WAIT: begin
               // Dropping psel mid-wait is a master abort
               if (!i_psel) begin
                  state_q <= IDLE;
               end else if (i_pen) begin
                  if (cnt_q == '0) begin
                     state_q   <= RESP;
                     pready_q  <= 1'b1;
                     pslverr_q <= err;
                     prdata_q  <= (write_q || err) ? '0 : rdata;
                     strobe_q  <= write_q && !err;
                     idx_q     <= (write_q && !err) ? 8'(addr_q) : '0;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_pready    = pready_q;
   assign o_pslverr   = pslverr_q;
   assign o_prdata    = prdata_q;
   assign o_wr_strobe = strobe_q;
   assign o_wr_idx    = idx_q;

endmodule

// File: tb/tb_apb_slave.sv
// Scoreboard bench for apb_slave: expected responses are queued at
// stimulus time and compared when o_pready rises.
module tb_apb_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0;
   logic        pen = 1'b0;
   logic        pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [15:0] pwdata = '0;
   logic [3:0]  wait_cfg = '0;
   logic [15:0] status = '0;
   logic        pready;
   logic [15:0] prdata;
   logic        pslverr;
   logic [15:0] ctrl;
   logic        strobe;
   logic [7:0]  wr_idx;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        wr;
      logic        err;
      logic [15:0] data;
      logic        strobe;
      logic [7:0]  idx;
   } exp_t;

   exp_t        sb [$];
   logic [15:0] mdl [8];

   always #5 clk = ~clk;

   apb_slave dut (
      .i_pclk      (clk),
      .i_prst_n    (rst_n),
      .i_psel      (psel),
      .i_pen       (pen),
      .i_pwrite    (pwrite),
      .i_paddr     (paddr),
      .i_pwdata    (pwdata),
      .o_pready    (pready),
      .o_prdata    (prdata),
      .o_pslverr   (pslverr),
      .i_wait_cfg  (wait_cfg),
      .i_status    (status),
      .o_ctrl      (ctrl),
      .o_wr_strobe (strobe),
      .o_wr_idx    (wr_idx)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {21'd0, pready, pslverr, strobe, prdata, wr_idx, ctrl};
   endfunction

   task automatic xfer(input logic wr, input logic [15:0] addr,
                       input logic [15:0] data, input int wc);
      exp_t e;
      int   n;
      bit   done;
      e.wr     = wr;
      e.err    = (addr >= 16'd8) || (wr && addr < 16'd2);
      e.data   = '0;
      if (!wr && !e.err) begin
         if (addr == 16'd0) e.data = 16'hA5B0;
         else if (addr == 16'd1) e.data = status;
         else e.data = mdl[addr[2:0]];
      end
      e.strobe = wr && !e.err;
      e.idx    = e.strobe ? addr[7:0] : 8'd0;
      sb.push_back(e);
      if (e.strobe) mdl[addr[2:0]] = data;
      @(negedge clk);
      psel = 1'b1; pen = 1'b0; pwrite = wr;
      paddr = addr; pwdata = data; wait_cfg = 4'(wc);
      @(negedge clk);
      pen = 1'b1; wait_cfg = 4'hF; pwdata = ~data;
      done = 0;
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (pready) done = 1;
         else check("quiet_wait",
                    {45'd0, pslverr, strobe, prdata}, 64'd0);
      end
      check("latency", 64'(n), 64'(wc + 1));
      e = sb.pop_front();
      if (done) begin
         check("pslverr", 64'(pslverr), 64'(e.err));
         if (!e.wr) check("prdata", 64'(prdata), 64'(e.data));
         check("wr_strobe", 64'(strobe), 64'(e.strobe));
         check("wr_idx", 64'(wr_idx), 64'(e.idx));
      end
      @(negedge clk);
      psel = 1'b0; pen = 1'b0; wait_cfg = 4'd0;
      @(posedge clk);
      #1;
      check("resp_one_cycle", all_outs() & ~64'hFFFF, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      repeat (2) @(negedge clk);
      check("reset_outs", all_outs(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      status = 16'hBEEF;

      xfer(1'b1, 16'd2, 16'h1234, 0);
      check("ctrl_after_wr", 64'(ctrl), 64'h1234);
      xfer(1'b0, 16'd2, 16'h0, 3);
      xfer(1'b0, 16'd0, 16'h0, 1);
      xfer(1'b1, 16'd0, 16'hDEAD, 0);
      xfer(1'b0, 16'd0, 16'h0, 0);
      xfer(1'b0, 16'd1, 16'h0, 2);
      xfer(1'b1, 16'd1, 16'h7777, 0);
      xfer(1'b0, 16'd8, 16'h0, 0);
      xfer(1'b0, 16'h0102, 16'h0, 0);
      xfer(1'b1, 16'h0102, 16'h5555, 1);
      check("ctrl_no_alias", 64'(ctrl), 64'h1234);

      // Access without a setup phase must be ignored
      @(negedge clk);
      psel = 1'b1; pen = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("no_setup", 64'(pready), 64'd0);
      end
      @(negedge clk);
      psel = 1'b0; pen = 1'b0;

      // Master abort after one wait cycle
      @(negedge clk);
      psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
      paddr = 16'd3; pwdata = 16'hFFFF; wait_cfg = 4'd3;
      @(negedge clk);
      pen = 1'b1;
      @(negedge clk);
      psel = 1'b0; pen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_quiet", {62'd0, pready, strobe}, 64'd0);
      end
      xfer(1'b0, 16'd3, 16'h0, 0);

      for (int i = 3; i < 8; i++)
         xfer(1'b1, 16'(i), 16'($urandom), $urandom_range(0, 4));
      for (int i = 2; i < 8; i++)
         xfer(1'b0, 16'(i), 16'h0, $urandom_range(0, 4));
      check("ctrl_model", 64'(ctrl), 64'(mdl[2]));

      // Reset in the middle of a write
      @(negedge clk);
      psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
      paddr = 16'd4; pwdata = 16'hCAFE; wait_cfg = 4'd3;
      @(negedge clk);
      pen = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_mid_outs", all_outs(), 64'd0);
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      @(negedge clk);
      psel = 1'b0; pen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b0, 16'd4, 16'h0, 0);
      xfer(1'b0, 16'd2, 16'h0, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
